// File: rtl/mem_arbiter.sv
// Arbitrates one single-port SRAM (1-cycle read latency) between instruction fetch and data access.
// Fixed priority favours D, and an anti-starvation counter lets IF win after MAX_WAIT denied cycles.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 4      // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_w_en,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_w_en,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IF,
        RESP_DRD,
        RESP_DWR
    } resp_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] starve_q, starve_d;
    resp_e      resp_q, resp_d;
    logic       if_rvalid_q, d_rvalid_q;
    logic       if_win;

    // IF wins when it has waited long enough or when D is idle; reset suppresses every grant.
    assign if_win = rst && if_req && ((starve_q == MAX_WAIT_C) || !d_req);

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_addr  = '0;
        mem_w_en  = 4'b0000;
        mem_wdata = 32'h0;
        if (if_win) begin
            if_gnt   = 1'b1;
            mem_addr = if_addr;
        end else if (rst && d_req) begin
            d_gnt     = 1'b1;
            mem_addr  = d_addr;
            mem_w_en  = d_w_en;
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = 4'd0;
        end else if (starve_q < MAX_WAIT_C) begin
            starve_d = starve_q + 4'd1;
        end

        resp_d = RESP_NONE;
        if (if_gnt) begin
            resp_d = RESP_IF;
        end else if (d_gnt) begin
            resp_d = (d_w_en == 4'b0000) ? RESP_DRD : RESP_DWR;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
    // the asynchronous reset clears in-flight responses so a grant just before reset never answers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q    <= 4'd0;
            resp_q      <= RESP_NONE;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            resp_q      <= resp_d;
            if_rvalid_q <= (resp_d == RESP_IF);
            d_rvalid_q  <= (resp_d == RESP_DRD) || (resp_d == RESP_DWR);
        end
    end

    // Read data comes straight from the SRAM in the response cycle; write acks return zero.
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rvalid_q ? mem_rdata : 32'h0;
    assign d_rdata   = (resp_q == RESP_DRD) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level model of grants, responses and memory contents.
module tb_mem_arbiter;

    localparam int ADDR_W   = 16;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_w_en;
    logic [31:0]       d_wdata;
    logic              d_gnt, d_rvalid;
    logic [31:0]       d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_w_en;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_w_en(d_w_en), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: 64 words, byte writes, write-first read data one cycle after the address.
    logic [31:0] sram [0:63];
    initial begin
        logic [31:0] w;
        for (int i = 0; i < 64; i++) sram[i] = 32'h0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            w = sram[mem_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (mem_w_en[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            sram[mem_addr[7:2]] = w;
            mem_rdata <= w;
        end
    end

    // Reference model: consecutive-denial count, the one outstanding response, and memory contents.
    int          m_wait = 0;
    bit          m_if_v = 1'b0, m_d_v = 1'b0;
    logic [31:0] m_if_data = 32'h0, m_d_data = 32'h0;
    logic [31:0] shadow [int];

    function automatic logic [31:0] peek(input logic [15:0] a);
        int k = int'(a[7:2]);
        return shadow.exists(k) ? shadow[k] : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare just after, then advance the model.
    task automatic cyc(input bit r, input bit ir, input logic [15:0] ia,
                       input bit dr, input logic [15:0] da, input logic [3:0] we,
                       input logic [31:0] wd, output bit ig, output bit dg);
        bit          eig, edg;
        logic [31:0] cur;
        @(negedge clk);
        rst = r; if_req = ir; if_addr = ia;
        d_req = dr; d_addr = da; d_w_en = we; d_wdata = wd;
        #1;
        if (!r) begin
            m_if_v = 1'b0; m_d_v = 1'b0; m_wait = 0;
        end
        eig = r && ir && (m_wait >= MAX_WAIT || !dr);
        edg = r && dr && !eig;

        chk("if_gnt",    {31'b0, if_gnt},    {31'b0, eig});
        chk("d_gnt",     {31'b0, d_gnt},     {31'b0, edg});
        chk("mem_addr",  {16'b0, mem_addr},  {16'b0, edg ? da : (eig ? ia : 16'h0)});
        chk("mem_w_en",  {28'b0, mem_w_en},  {28'b0, edg ? we : 4'h0});
        chk("mem_wdata", mem_wdata,          edg ? wd : 32'h0);
        chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, m_if_v});
        chk("if_rdata",  if_rdata,           m_if_v ? m_if_data : 32'h0);
        chk("d_rvalid",  {31'b0, d_rvalid},  {31'b0, m_d_v});
        chk("d_rdata",   d_rdata,            m_d_v ? m_d_data : 32'h0);

        if (!r) begin
            m_wait = 0;
            m_if_v = 1'b0; m_d_v = 1'b0;
        end else begin
            m_wait   = (ir && !eig) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
            m_if_v   = eig;
            m_if_data = eig ? peek(ia) : 32'h0;
            m_d_v    = edg;
            m_d_data = 32'h0;
            if (edg && we == 4'h0) begin
                m_d_data = peek(da);
            end else if (edg) begin
                cur = peek(da);
                for (int b = 0; b < 4; b++)
                    if (we[b]) cur[8*b +: 8] = wd[8*b +: 8];
                shadow[int'(da[7:2])] = cur;
            end
        end
        ig = eig;
        dg = edg;
    endtask

    bit          ig, dg;
    bit          ip, dp;
    logic [15:0] ra_if, ra_d;
    logic [3:0]  rwe;
    logic [31:0] rwd;
    bit          rr;

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_addr = '0; d_w_en = 4'h0; d_wdata = 32'h0;

        // Reset held with requests active: everything stays quiet.
        cyc(0, 1, 16'h0010, 1, 16'h0020, 4'hF, 32'hAAAA5555, ig, dg);
        cyc(0, 1, 16'h0010, 1, 16'h0020, 4'hF, 32'hAAAA5555, ig, dg);

        // First cycle after release grants; preload 0x10 and 0x20 through the D port.
        cyc(1, 0, 16'h0000, 1, 16'h0010, 4'hF, 32'hDEADBEEF, ig, dg);
        cyc(1, 0, 16'h0000, 1, 16'h0020, 4'hF, 32'hFFFFFFFF, ig, dg);

        // IF read of 0x10 then idle to see the response.
        cyc(1, 1, 16'h0010, 0, 16'h0000, 4'h0, 32'h0, ig, dg);
        cyc(1, 0, 16'h0000, 0, 16'h0000, 4'h0, 32'h0, ig, dg);

        // Conflict: D wins, then IF is served when D drops.
        cyc(1, 1, 16'h0010, 1, 16'h0020, 4'h0, 32'h0, ig, dg);
        cyc(1, 1, 16'h0010, 0, 16'h0000, 4'h0, 32'h0, ig, dg);
        cyc(1, 0, 16'h0000, 0, 16'h0000, 4'h0, 32'h0, ig, dg);

        // Starvation: both held continuously; IF must break through periodically.
        for (int i = 0; i < 14; i++)
            cyc(1, 1, 16'h0010, 1, 16'h0020, 4'h0, 32'h0, ig, dg);
        cyc(1, 0, 16'h0000, 0, 16'h0000, 4'h0, 32'h0, ig, dg);

        // Byte write then read-after-write on consecutive cycles.
        cyc(1, 0, 16'h0000, 1, 16'h0020, 4'b0011, 32'h12345678, ig, dg);
        cyc(1, 0, 16'h0000, 1, 16'h0020, 4'b0000, 32'h0, ig, dg);
        cyc(1, 0, 16'h0000, 0, 16'h0000, 4'h0, 32'h0, ig, dg);

        // Back-to-back IF, D read, IF.
        cyc(1, 1, 16'h0010, 0, 16'h0000, 4'h0, 32'h0, ig, dg);
        cyc(1, 0, 16'h0000, 1, 16'h0020, 4'h0, 32'h0, ig, dg);
        cyc(1, 1, 16'h0020, 0, 16'h0000, 4'h0, 32'h0, ig, dg);
        cyc(1, 0, 16'h0000, 0, 16'h0000, 4'h0, 32'h0, ig, dg);

        // Reset in the cycle after a D grant swallows the response; IF works after release.
        cyc(1, 0, 16'h0000, 1, 16'h0010, 4'h0, 32'h0, ig, dg);
        cyc(0, 1, 16'h0010, 1, 16'h0020, 4'hF, 32'h0BADF00D, ig, dg);
        cyc(0, 1, 16'h0010, 1, 16'h0020, 4'hF, 32'h0BADF00D, ig, dg);
        cyc(1, 1, 16'h0010, 0, 16'h0000, 4'h0, 32'h0, ig, dg);
        cyc(1, 0, 16'h0000, 0, 16'h0000, 4'h0, 32'h0, ig, dg);

        // Randomized traffic obeying the hold-until-grant rule, with occasional resets.
        ip = 1'b0; dp = 1'b0;
        ra_if = '0; ra_d = '0; rwe = 4'h0; rwd = 32'h0;
        for (int n = 0; n < 600; n++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1'b1;
                ra_if = {8'h00, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (!dp && $urandom_range(0, 1) != 0) begin
                dp = 1'b1;
                ra_d = {8'h00, 6'($urandom_range(0, 63)), 2'b00};
                rwe  = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
                rwd  = $urandom;
            end
            rr = ($urandom_range(0, 99) != 0);
            cyc(rr, ip, ip ? ra_if : 16'h0, dp, dp ? ra_d : 16'h0,
                dp ? rwe : 4'h0, dp ? rwd : 32'h0, ig, dg);
            if (ig) ip = 1'b0;
            if (dg) dp = 1'b0;
            if (!rr) begin
                ip = 1'b0; dp = 1'b0;
            end
        end
        cyc(1, 0, 16'h0000, 0, 16'h0000, 4'h0, 32'h0, ig, dg);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
